// File: rtl/ibuf_ctrl_if.sv
// ibuf_ctrl_if -- handshake and status bundle between the input-buffer
// controller and its neighbours (upstream stream, input buffer, crossbar).
//
//   slave  : the controller side (ibuf_ctrl)
//   master : the driving side (upstream source / crossbar / testbench)
//
//   i_valid, i_data         upstream element stream
//   o_ready                 controller accepts an element this cycle
//   o_ibuf_we, o_ibuf_data  shift-enable and stage-0 data for the buffer
//   o_start, i_done         compute start pulse / compute finished
//   i_clear                 synchronous abort of the current frame
//   o_busy, o_count         status: not filling / elements loaded in frame
//   o_frames                completed-frame counter (wraps)
interface ibuf_ctrl_if #(
    parameter int datatype_size = 8,
    parameter int fifo_length   = 5,
    parameter int cnt_width     = 8
);
    localparam int DEPTH = fifo_length * 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                     i_valid;
    logic [datatype_size-1:0] i_data;
    logic                     o_ready;
    logic                     o_ibuf_we;
    logic [datatype_size-1:0] o_ibuf_data;
    logic                     o_start;
    logic                     i_done;
    logic                     i_clear;
    logic                     o_busy;
    logic [CW-1:0]            o_count;
    logic [cnt_width-1:0]     o_frames;

    modport slave (
        input  i_valid, i_data, i_done, i_clear,
        output o_ready, o_ibuf_we, o_ibuf_data, o_start, o_busy, o_count, o_frames
    );

    modport master (
        output i_valid, i_data, i_done, i_clear,
        input  o_ready, o_ibuf_we, o_ibuf_data, o_start, o_busy, o_count, o_frames
    );
endinterface

// File: rtl/ibuf_ctrl.sv
// ibuf_ctrl -- fills a DEPTH-element shift buffer (DEPTH = fifo_length*2)
// from a valid/ready stream, then fires a one-cycle start to the crossbar
// and waits for its done before accepting the next frame.
//
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ibuf_ctrl_if.slave (stream in, buffer write, start/done, status)
//
// Frame flow: FILL (accept DEPTH elements) -> SETTLE (one cycle for the
// last element to land in the buffer registers) -> START (o_start pulse)
// -> COMPUTE (wait for i_done) -> FILL. i_clear aborts to FILL from any
// state without counting a frame.
module ibuf_ctrl #(
    parameter int datatype_size = 8,
    parameter int fifo_length   = 5,
    parameter int cnt_width     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    ibuf_ctrl_if.slave  bus
);
    localparam int DEPTH = fifo_length * 2;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FILL, SETTLE, START, COMPUTE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [cnt_width-1:0] frames, frames_nxt;
    // Holds o_ready low until the first edge after reset release.
    logic                 rdy_en;
    logic                 accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            cnt    <= '0;
            frames <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            frames <= frames_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        frames_nxt = frames;
        if (bus.i_clear) begin
            // Abort wins over accept and done in the same cycle.
            state_nxt = FILL;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        cnt_nxt = cnt + CW'(1);
                        if (cnt == CW'(DEPTH - 1))
                            state_nxt = SETTLE;
                    end
                end
                SETTLE:  state_nxt = START;
                START:   state_nxt = COMPUTE;
                COMPUTE: begin
                    if (bus.i_done) begin
                        state_nxt  = FILL;
                        cnt_nxt    = '0;
                        frames_nxt = frames + cnt_width'(1);
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    assign bus.o_ready     = (state == FILL) && rdy_en && !bus.i_clear;
    assign accept          = bus.i_valid && bus.o_ready;
    assign bus.o_ibuf_we   = accept;
    assign bus.o_ibuf_data = bus.i_data[datatype_size-1:0];
    assign bus.o_start     = (state == START) && !bus.i_clear;
    assign bus.o_busy      = (state != FILL);
    assign bus.o_count     = cnt;
    assign bus.o_frames    = frames;
endmodule

// File: doc/ibuf_ctrl.md
IBUF_CTRL -- requirements
Module: ibuf_ctrl

Interface
REQ-001 SHALL have parameter datatype_size, default 8, element width in bits.
REQ-002 SHALL have parameter fifo_length, default 5; buffer depth DEPTH = fifo_length*2 elements.
REQ-003 SHALL have parameter cnt_width, default 8, width of the frame counter.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_valid, input, 1, upstream element valid.
REQ-007 SHALL have port i_data, input, datatype_size, upstream element.
REQ-008 SHALL have port o_ready, output, 1, controller accepts an element this cycle.
REQ-009 SHALL have port o_ibuf_we, output, 1, shift-enable to the input buffer.
REQ-010 SHALL have port o_ibuf_data, output, datatype_size, element driven into buffer stage 0.
REQ-011 SHALL have port o_start, output, 1, single-cycle compute start to the crossbar.
REQ-012 SHALL have port i_done, input, 1, crossbar compute finished.
REQ-013 SHALL have port i_clear, input, 1, synchronous abort of the current frame.
REQ-014 SHALL have port o_busy, output, 1, high while not in FILL.
REQ-015 SHALL have port o_count, output, clog2(DEPTH+1), elements loaded in the current frame.
REQ-016 SHALL have port o_frames, output, cnt_width, completed frames (i_done accepted).

Function
REQ-017 SHALL implement states FILL, SETTLE, START, COMPUTE.
REQ-018 In FILL: o_ready=1; accept = i_valid & o_ready; o_ibuf_we = accept (combinational); o_ibuf_data = i_data.
REQ-019 Each accept SHALL increment o_count by 1 at the clock edge.
REQ-020 An accept while o_count = DEPTH-1 SHALL set o_count to DEPTH and move to SETTLE.
REQ-021 SETTLE SHALL last exactly 1 cycle (buffer register latency), then go to START.
REQ-022 START SHALL assert o_start for exactly 1 cycle, then go to COMPUTE.
REQ-023 COMPUTE SHALL hold until i_done=1; on that edge: go to FILL, o_count=0, o_frames+1.
REQ-024 o_frames SHALL wrap from 2^cnt_width-1 to 0 without flag.
REQ-025 Outside FILL: o_ready=0, o_ibuf_we=0; i_valid ignored, no buffer shift.
REQ-026 i_done outside COMPUTE SHALL be ignored; i_done in the START cycle SHALL be ignored.
REQ-027 i_clear=1 in any state SHALL, at the edge, force FILL, o_count=0, o_frames unchanged; o_ready, o_ibuf_we and o_start SHALL be 0 in that cycle.
REQ-028 i_clear SHALL take priority over accept and i_done in the same cycle.
REQ-029 Latency from last accept edge to o_start high SHALL be 2 cycles.
REQ-030 Back-to-back accepts SHALL be sustained at 1 element/cycle in FILL.
REQ-031 o_ibuf_data SHALL equal i_data in all states (write qualified only by o_ibuf_we).

Reset
REQ-032 rst_n=0 SHALL asynchronously force FILL, o_count=0, o_frames=0, o_start=0, o_busy=0.
REQ-033 During reset o_ready and o_ibuf_we SHALL be 0; o_ready=1 from the first edge after rst_n rises.
REQ-034 Reset asserted mid-frame or mid-COMPUTE SHALL abandon the frame with no o_start or o_frames update.

Verification
REQ-035 Defaults, i_valid=1 for 10 cycles with data 1..10 -> 10 o_ibuf_we pulses, o_count 1..10, o_start exactly 2 cycles after 10th accept, o_busy=1.
REQ-036 i_valid toggled 1,0,1,0 -> o_count advances only on valid cycles; 10th accept still gives o_start 2 cycles later.
REQ-037 In COMPUTE, i_valid=1 for 5 cycles, then i_done=1 -> no o_ibuf_we during COMPUTE, o_frames 0->1, o_count=0, o_ready=1 next cycle.
REQ-038 i_clear=1 with o_count=6 and i_valid=1 -> no write that cycle, o_count=0, state FILL, o_frames unchanged.
REQ-039 rst_n low mid-COMPUTE -> outputs immediately at reset values; no o_start; o_frames=0.
REQ-040 cnt_width=2, run 5 frames -> o_frames sequence 1,2,3,0,1.
